// File: rtl/nibble_pack_fifo_if.sv
// Nibble-write / byte-read bundle for nibble_pack_fifo.
// The master side is the producer/consumer; the slave side is the FIFO itself.
interface nibble_pack_fifo_if #(
   parameter int unsigned IN_WIDTH   = 4,
   parameter int unsigned DEPTH_BITS = 6
);
   logic [IN_WIDTH-1:0]   data;
   logic                  we;
   logic                  re;
   logic [2*IN_WIDTH-1:0] q;
   logic                  full;
   logic                  empty;
   logic                  pend;
   logic [DEPTH_BITS:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output data, we, re,
      input  q, full, empty, pend, count, overflow, underflow
   );

   modport slave (
      input  data, we, re,
      output q, full, empty, pend, count, overflow, underflow
   );
endinterface

// File: rtl/nibble_pack_fifo.sv
// Packs pairs of nibbles (low nibble first) into bytes and buffers them for a byte reader.
// Q is registered with one cycle of read latency; there is no write-to-read bypass.
module nibble_pack_fifo #(
   parameter int unsigned IN_WIDTH   = 4,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned DEPTH_BITS = 6
) (
   input logic               CLK,
   input logic               RESET,
   nibble_pack_fifo_if.slave bus
);
   localparam int unsigned ByteW = 2 * IN_WIDTH;
   localparam logic [DEPTH_BITS:0] FullCount = (DEPTH_BITS + 1)'(DEPTH);

   logic [ByteW-1:0]      mem_q [DEPTH];
   logic [IN_WIDTH-1:0]   hold_q, hold_d;
   logic                  pend_q, pend_d;
   logic [DEPTH_BITS-1:0] wptr_q, wptr_d;
   logic [DEPTH_BITS-1:0] rptr_q, rptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic [ByteW-1:0]      q_q, q_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic full, empty, wr_nib, wr_byte, rd;

   always_comb begin
      full        = (count_q == FullCount);
      empty       = (count_q == '0);
      wr_nib      = bus.we & ~full;
      wr_byte     = wr_nib & pend_q;
      rd          = bus.re & ~empty;

      hold_d      = hold_q;
      pend_d      = pend_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      q_d         = q_q;
      overflow_d  = bus.we & full;
      underflow_d = bus.re & empty;

      if (wr_nib) begin
         if (pend_q) begin
            wptr_d = wptr_q + 1'b1;
            pend_d = 1'b0;
         end else begin
            hold_d = bus.data;
            pend_d = 1'b1;
         end
      end

      if (rd) begin
         q_d    = mem_q[rptr_q];
         rptr_d = rptr_q + 1'b1;
      end

      // Byte completion and read in the same cycle leave the count unchanged.
      unique case ({wr_byte, rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hold_q      <= '0;
         pend_q      <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         q_q         <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         q_q         <= q_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage has no reset; pointers and count define which entries are valid.
   always_ff @(posedge CLK) begin
      if (!RESET && wr_byte) begin
         mem_q[wptr_q] <= {bus.data, hold_q};
      end
   end

   assign bus.q         = q_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.pend      = pend_q;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_nibble_pack_fifo.sv
// Directed bench for nibble_pack_fifo: packing order, flags, pulses, wrap and reset.
module tb_nibble_pack_fifo;
   logic CLK;
   logic RESET;
   int   n_cmp;
   int   n_err;
   logic [7:0] exp_q [$];

   nibble_pack_fifo_if #(.IN_WIDTH(4), .DEPTH_BITS(6)) bus ();

   nibble_pack_fifo #(
      .IN_WIDTH  (4),
      .DEPTH     (64),
      .DEPTH_BITS(6)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_nib(input logic [3:0] d);
      bus.we   = 1'b1;
      bus.data = d;
      tick();
      bus.we   = 1'b0;
   endtask

   task automatic apply_reset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      n_cmp++;
      if (bus.q !== 8'h00) begin
         n_err++; $display("FAIL reset_q: got %h want 00", bus.q);
      end
      n_cmp++;
      if (bus.empty !== 1'b1) begin
         n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty);
      end
      n_cmp++;
      if (bus.full !== 1'b0) begin
         n_err++; $display("FAIL reset_full: got %b want 0", bus.full);
      end
      n_cmp++;
      if (bus.pend !== 1'b0) begin
         n_err++; $display("FAIL reset_pend: got %b want 0", bus.pend);
      end
      n_cmp++;
      if (bus.count !== 7'd0) begin
         n_err++; $display("FAIL reset_count: got %0d want 0", bus.count);
      end
   endtask

   task automatic test_pack();
      logic [3:0] nibs [6];
      logic [7:0] want [3];
      nibs = '{4'h1, 4'ha, 4'hb, 4'h2, 4'h3, 4'hc};
      want = '{8'ha1, 8'h2b, 8'hc3};
      for (int i = 0; i < 6; i++) write_nib(nibs[i]);
      n_cmp++;
      if (bus.count !== 7'd3) begin
         n_err++; $display("FAIL pack_count: got %0d want 3", bus.count);
      end
      bus.re = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (bus.q !== want[i]) begin
            n_err++; $display("FAIL pack_q%0d: got %h want %h", i, bus.q, want[i]);
         end
      end
      bus.re = 1'b0;
      n_cmp++;
      if (bus.empty !== 1'b1) begin
         n_err++; $display("FAIL pack_empty: got %b want 1", bus.empty);
      end
   endtask

   task automatic test_pend_underflow();
      write_nib(4'h5);
      n_cmp++;
      if (bus.pend !== 1'b1 || bus.empty !== 1'b1) begin
         n_err++; $display("FAIL pend_flags: got pend=%b empty=%b want 1 1", bus.pend, bus.empty);
      end
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      n_cmp++;
      if (bus.q !== 8'hc3) begin
         n_err++; $display("FAIL underflow_q_hold: got %h want c3", bus.q);
      end
      n_cmp++;
      if (bus.underflow !== 1'b1) begin
         n_err++; $display("FAIL underflow_pulse: got %b want 1", bus.underflow);
      end
      tick();
      n_cmp++;
      if (bus.underflow !== 1'b0) begin
         n_err++; $display("FAIL underflow_clear: got %b want 0", bus.underflow);
      end
      // Complete the pending byte and drain it so the next fill starts mid-array.
      write_nib(4'h6);
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      n_cmp++;
      if (bus.q !== 8'h65) begin
         n_err++; $display("FAIL pend_complete_q: got %h want 65", bus.q);
      end
   endtask

   task automatic test_fill_wrap();
      logic [3:0] k4;
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 64; k++) begin
            k4 = 4'(k);
            write_nib(~k4);
            write_nib(k4);
         end
         n_cmp++;
         if (bus.full !== 1'b1 || bus.count !== 7'd64) begin
            n_err++; $display("FAIL fill%0d_full: got full=%b count=%0d want 1 64",
                              pass, bus.full, bus.count);
         end
         write_nib(4'h9);
         n_cmp++;
         if (bus.overflow !== 1'b1 || bus.count !== 7'd64 || bus.pend !== 1'b0) begin
            n_err++; $display("FAIL fill%0d_overflow: got ovf=%b count=%0d pend=%b want 1 64 0",
                              pass, bus.overflow, bus.count, bus.pend);
         end
         tick();
         n_cmp++;
         if (bus.overflow !== 1'b0) begin
            n_err++; $display("FAIL fill%0d_overflow_clear: got %b want 0", pass, bus.overflow);
         end
         bus.re = 1'b1;
         for (int k = 0; k < 64; k++) begin
            tick();
            k4 = 4'(k);
            n_cmp++;
            if (bus.q !== {k4, ~k4}) begin
               n_err++; $display("FAIL drain%0d_q%0d: got %h want %h", pass, k, bus.q, {k4, ~k4});
            end
         end
         bus.re = 1'b0;
         n_cmp++;
         if (bus.empty !== 1'b1 || bus.count !== 7'd0) begin
            n_err++; $display("FAIL drain%0d_empty: got empty=%b count=%0d want 1 0",
                              pass, bus.empty, bus.count);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] b;
      logic [7:0] e;
      apply_reset();
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         write_nib(4'(i));
         write_nib(4'h1);
         exp_q.push_back({4'h1, 4'(i)});
      end
      write_nib(4'h7);
      n_cmp++;
      if (bus.count !== 7'd5 || bus.pend !== 1'b1) begin
         n_err++; $display("FAIL sim_setup: got count=%0d pend=%b want 5 1", bus.count, bus.pend);
      end
      bus.we = 1'b1; bus.data = 4'h9; bus.re = 1'b1;
      tick();
      bus.we = 1'b0; bus.re = 1'b0;
      e = exp_q.pop_front();
      exp_q.push_back(8'h97);
      n_cmp++;
      if (bus.count !== 7'd5 || bus.pend !== 1'b0 || bus.q !== e) begin
         n_err++; $display("FAIL sim_wr_rd: got count=%0d pend=%b q=%h want 5 0 %h",
                           bus.count, bus.pend, bus.q, e);
      end
      for (int i = 0; i < 59; i++) begin
         b = 8'(i * 3 + 32);
         write_nib(b[3:0]);
         write_nib(b[7:4]);
         exp_q.push_back(b);
      end
      n_cmp++;
      if (bus.full !== 1'b1 || bus.count !== 7'd64) begin
         n_err++; $display("FAIL sim_full: got full=%b count=%0d want 1 64", bus.full, bus.count);
      end
      bus.we = 1'b1; bus.data = 4'hf; bus.re = 1'b1;
      tick();
      bus.we = 1'b0; bus.re = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.count !== 7'd63 || bus.overflow !== 1'b1 || bus.q !== e || bus.pend !== 1'b0) begin
         n_err++; $display("FAIL sim_full_wr_rd: got count=%0d ovf=%b q=%h pend=%b want 63 1 %h 0",
                           bus.count, bus.overflow, bus.q, bus.pend, e);
      end
      // Completing write and read together while empty: the read is refused.
      apply_reset();
      write_nib(4'h8);
      bus.we = 1'b1; bus.data = 4'h4; bus.re = 1'b1;
      tick();
      bus.we = 1'b0; bus.re = 1'b0;
      n_cmp++;
      if (bus.underflow !== 1'b1 || bus.count !== 7'd1 || bus.q !== 8'h00) begin
         n_err++; $display("FAIL sim_empty_wr_rd: got unf=%b count=%0d q=%h want 1 1 00",
                           bus.underflow, bus.count, bus.q);
      end
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      n_cmp++;
      if (bus.q !== 8'h48) begin
         n_err++; $display("FAIL sim_empty_late_read: got %h want 48", bus.q);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         write_nib(4'(2 * i + 2));
         write_nib(4'(2 * i + 3));
      end
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      write_nib(4'ha);
      n_cmp++;
      if (bus.count !== 7'd3 || bus.pend !== 1'b1 || bus.q !== 8'h32) begin
         n_err++; $display("FAIL mid_setup: got count=%0d pend=%b q=%h want 3 1 32",
                           bus.count, bus.pend, bus.q);
      end
      apply_reset();
      n_cmp++;
      if (bus.count !== 7'd0 || bus.pend !== 1'b0 || bus.q !== 8'h00 || bus.empty !== 1'b1) begin
         n_err++; $display("FAIL mid_reset: got count=%0d pend=%b q=%h empty=%b want 0 0 00 1",
                           bus.count, bus.pend, bus.q, bus.empty);
      end
      write_nib(4'h1);
      write_nib(4'h1);
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      n_cmp++;
      if (bus.q !== 8'h11) begin
         n_err++; $display("FAIL mid_after_q: got %h want 11", bus.q);
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      RESET    = 1'b1;
      bus.we   = 1'b0;
      bus.re   = 1'b0;
      bus.data = 4'h0;
      test_reset();
      test_pack();
      test_pend_underflow();
      test_fill_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
